// File: rtl/mux2_arb_pkg.sv
// Shared constants for the two-requester mux arbiter: state encoding, select
// values, default timing parameters and the tie-break helper.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10,
    GAP     = 2'b11
  } arb_state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int DEF_SWITCH_GAP = 1;
  localparam int DEF_MAX_HOLD   = 8;

  // Returns 1 when B should win: sole requester, or tie with A served last.
  function automatic logic pick_b(input logic req_a, input logic req_b,
                                  input logic last_b);
    if (req_a && req_b) return !last_b;
    return req_b;
  endfunction

endpackage

// File: rtl/mux2_arb_timer.sv
// Loadable down-counter that stops at zero; shared by the gap and hold timing.
module mux2_arb_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = load_val;
    else if (dec && !zero)      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux2_arbiter.sv
// Two-requester arbiter for a shared 2:1 mux with a dead gap between owners.
// Define MUX2_ARB_TIMEOUT_EN to force release after MAX_HOLD contested cycles.
module mux2_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int SWITCH_GAP = DEF_SWITCH_GAP,
  parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic done,
  output logic gnt_a,
  output logic gnt_b,
  output logic sel,
  output logic busy,
  output logic tmo
);

  if (SWITCH_GAP < 1 || SWITCH_GAP > 15 || MAX_HOLD < 1) begin : g_bad_cfg
    $error("mux2_arbiter: SWITCH_GAP must be 1..15 and MAX_HOLD >= 1");
  end

  localparam logic [3:0] GAP_LOAD = 4'(SWITCH_GAP - 1);

  arb_state_e state_d, state_q;
  logic       last_b_d, last_b_q;
  logic       sel_d, sel_q;
  logic       gnt_a_d, gnt_a_q, gnt_b_d, gnt_b_q, busy_d, busy_q;
  logic       gap_load, gap_dec, gap_zero;
  logic       timeout_a, timeout_b;
  logic       win_b;

  mux2_arb_timer #(.W(4)) u_gap_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);

  logic contested, hold_load, hold_dec, hold_zero;
  logic tmo_d, tmo_q;

  // Counting only runs while the owner stays and the other side waits.
  assign contested = (state_q == GRANT_A && req_b) || (state_q == GRANT_B && req_a);
  assign hold_load = !contested;
  assign hold_dec  = contested && !hold_zero;
  assign timeout_a = (state_q == GRANT_A) && req_b && hold_zero;
  assign timeout_b = (state_q == GRANT_B) && req_a && hold_zero;

  mux2_arb_timer #(.W(HOLD_W)) u_hold_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (hold_load),
    .load_val (HOLD_W'(MAX_HOLD - 1)),
    .dec      (hold_dec),
    .zero     (hold_zero)
  );

  // Forced release only when the owner was not already letting go.
  always_comb begin
    tmo_d = (timeout_a && req_a && !done) || (timeout_b && req_b && !done);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= 1'b0;
    else        tmo_q <= tmo_d;
  end

  assign tmo = tmo_q;
`else
  assign timeout_a = 1'b0;
  assign timeout_b = 1'b0;
  assign tmo       = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    last_b_d = last_b_q;
    sel_d    = sel_q;
    gap_dec  = 1'b0;
    win_b    = pick_b(req_a, req_b, last_b_q);

    unique case (state_q)
      IDLE: begin
        if (req_a || req_b) state_d = win_b ? GRANT_B : GRANT_A;
      end
      GRANT_A: begin
        if (done || !req_a || timeout_a) state_d = GAP;
      end
      GRANT_B: begin
        if (done || !req_b || timeout_b) state_d = GAP;
      end
      GAP: begin
        if (!gap_zero)           gap_dec = 1'b0 | 1'b1;
        else if (req_a || req_b) state_d = win_b ? GRANT_B : GRANT_A;
        else                     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    gap_load = (state_d == GAP) && (state_q != GAP);

    // Select and tie-break history move only on entry into a grant.
    if (state_d == GRANT_A && state_q != GRANT_A) begin
      sel_d    = SEL_A;
      last_b_d = 1'b0;
    end else if (state_d == GRANT_B && state_q != GRANT_B) begin
      sel_d    = SEL_B;
      last_b_d = 1'b1;
    end

    gnt_a_d = (state_d == GRANT_A);
    gnt_b_d = (state_d == GRANT_B);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_b_q <= 1'b1;
      sel_q    <= SEL_A;
      gnt_a_q  <= 1'b0;
      gnt_b_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_b_q <= last_b_d;
      sel_q    <= sel_d;
      gnt_a_q  <= gnt_a_d;
      gnt_b_q  <= gnt_b_d;
      busy_q   <= busy_d;
    end
  end

  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign sel   = sel_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_mux2_arbiter.sv
// Directed bench for mux2_arbiter: default instance plus a SWITCH_GAP=3/MAX_HOLD=4 one.
module tb_mux2_arbiter;

  logic clk = 1'b0;
  logic rst_n, req_a, req_b, done;
  logic g0a, g0b, s0, b0, t0;
  logic g3a, g3b, s3, b3, t3;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux2_arbiter u0 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .done(done),
    .gnt_a(g0a), .gnt_b(g0b), .sel(s0), .busy(b0), .tmo(t0)
  );

  mux2_arbiter #(.SWITCH_GAP(3), .MAX_HOLD(4)) u3 (
    .clk(clk), .rst_n(rst_n), .req_a(req_a), .req_b(req_b), .done(done),
    .gnt_a(g3a), .gnt_b(g3b), .sel(s3), .busy(b3), .tmo(t3)
  );

  // Observed vector order: {gnt_a, gnt_b, sel, busy, tmo}
  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic c0(input string tag, input logic [4:0] exp);
    check(tag, {g0a, g0b, s0, b0, t0}, exp);
  endtask

  task automatic c3(input string tag, input logic [4:0] exp);
    check(tag, {g3a, g3b, s3, b3, t3}, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (!(g0a && g0b) && !(g3a && g3b)) else begin
        failures++;
        $error("FAIL mutex observed=%b%b/%b%b expected=no double grant", g0a, g0b, g3a, g3b);
      end
    end
  end

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; done = 1'b0;
    #12;
    c0("reset_u0", 5'b00000);
    c3("reset_u3", 5'b00000);
    @(negedge clk) rst_n = 1'b1;

    // Single requester, 1-cycle latency, release and re-grant of the same side
    tick();                 c0("idle_no_req", 5'b00000);
    req_a = 1'b1;  tick();  c0("grant_a_latency", 5'b10010);
    done = 1'b1;   tick();  c0("done_to_gap", 5'b00010);
    done = 1'b0;   tick();  c0("regrant_a", 5'b10010);
    req_a = 1'b0;  tick();  c0("drop_to_gap", 5'b00010);
    tick();                 c0("gap_to_idle", 5'b00000);
    done = 1'b1;   tick();  c0("done_in_idle", 5'b00000);
    done = 1'b0;

    // Both requesting from reset: A first, then strict alternation
    rst_n = 1'b0; #1;
    c0("async_reset_idle", 5'b00000);
    @(negedge clk) rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    tick();                 c0("tie_a_first", 5'b10010);
    done = 1'b1;   tick();  c0("alt_gap1", 5'b00010);
    tick();                 c0("done_in_gap_ignored", 5'b01110);
    tick();                 c0("alt_gap2_sel_holds", 5'b00110);
    done = 1'b0;   tick();  c0("alt_grant_a", 5'b10010);
    done = 1'b1;   tick();  c0("alt_gap3", 5'b00010);
    done = 1'b0;   tick();  c0("alt_grant_b", 5'b01110);
    req_a = 1'b0; req_b = 1'b0;
    tick();                 c0("alt_release", 5'b00110);
    tick();                 c0("idle_sel_holds", 5'b00100);

    // Three-cycle gap on the wide instance
    rst_n = 1'b0; #1;
    @(negedge clk) rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    tick();                 c3("gap3_grant_a", 5'b10010);
    req_a = 1'b0;
    tick();                 c3("gap3_cycle1", 5'b00010);
    tick();                 c3("gap3_cycle2", 5'b00010);
    tick();                 c3("gap3_cycle3", 5'b00010);
    tick();                 c3("gap3_grant_b", 5'b01110);

    // Asynchronous reset between edges while B owns
    #2 rst_n = 1'b0;
    #1;
    c3("midgrant_reset_u3", 5'b00000);
    c0("midgrant_reset_u0", 5'b00000);

    // A holds while B waits
    @(negedge clk) rst_n = 1'b1;
    req_a = 1'b1; req_b = 1'b1;
    tick();                 c3("hold_cyc1", 5'b10010);
    tick();                 c3("hold_cyc2", 5'b10010);
    tick();                 c3("hold_cyc3", 5'b10010);
    tick();                 c3("hold_cyc4", 5'b10010);
`ifdef MUX2_ARB_TIMEOUT_EN
    tick();                 c3("timeout_pulse", 5'b00011);
    tick();                 c3("timeout_gap2", 5'b00010);
    tick();                 c3("timeout_gap3", 5'b00010);
    tick();                 c3("timeout_grant_b", 5'b01110);
`else
    tick();                 c3("hold_cyc5", 5'b10010);
    tick();                 c3("hold_cyc6", 5'b10010);
    tick();                 c3("hold_cyc7", 5'b10010);
    tick();                 c3("hold_cyc8", 5'b10010);
    c0("hold_u0_cyc8", 5'b10010);
`endif

    req_a = 1'b0; req_b = 1'b0;
    repeat (6) tick();
    c0("final_idle_u0", 5'b00000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux2_arbiter.md
MUX2_ARBITER -- requirements
Module: mux2_arbiter

Interface
REQ-001 Parameter SWITCH_GAP, default 1, dead cycles with both grants low between owners; legal range 1..15.
REQ-002 Parameter MAX_HOLD, default 8, maximum consecutive grant cycles while the other side waits; used only under REQ-027.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST_N  input  1  reset, asynchronous, active-low.
REQ-005 REQ_A  input  1  requester A wants the shared 2:1 mux output.
REQ-006 REQ_B  input  1  requester B wants the shared 2:1 mux output.
REQ-007 DONE  input  1  current owner releases the mux; ignored when no grant is high.
REQ-008 GNT_A  output  1  A owns the mux.
REQ-009 GNT_B  output  1  B owns the mux.
REQ-010 SEL  output  1  mux select; 0 routes A, 1 routes B.
REQ-011 BUSY  output  1  high in any state other than IDLE.
REQ-012 TMO  output  1  one-cycle pulse on forced release; constant 0 without the REQ-027 macro.

Function
REQ-013 FSM states: IDLE, GRANT_A, GRANT_B, GAP; all outputs registered.
REQ-014 Arbitration: only one request -> that side wins; both requests -> the side not served last wins; LAST flag updated on every grant.
REQ-015 IDLE: request sampled at edge n -> GNT_x and SEL high/low at edge n+1 (1-cycle latency); no request -> stay IDLE.
REQ-016 SEL changes only on the edge that enters GRANT_A/GRANT_B; SEL holds its value in GAP and IDLE.
REQ-017 GRANT_x: stay while REQ_x=1 and DONE=0; DONE=1 or REQ_x=0 -> GAP on next edge, GNT_x low.
REQ-018 GAP: both grants low for exactly SWITCH_GAP cycles; on the last GAP cycle arbitrate per REQ-014 and go to GRANT_x; no request -> IDLE.
REQ-019 GNT_A and GNT_B never high in the same cycle; never high in adjacent cycles for different owners.
REQ-020 DONE and the other side's request in the same cycle: release, GAP, then grant the other side.
REQ-021 Both requests dropped during GAP: go to IDLE, no grant.
REQ-022 Same side re-requests after release with no competitor: re-granted after GAP.
REQ-023 GAP counter is 4 bits; the hold counter is wide enough for MAX_HOLD and saturates without wrapping.

Reset
REQ-024 RST_N low: state IDLE, GNT_A=0, GNT_B=0, SEL=0, BUSY=0, TMO=0, counters 0, LAST=B so A wins the first tie.
REQ-025 Reset asserted mid-grant drops the grants immediately, without waiting for CLK.
REQ-026 First arbitration occurs on the first CLK edge after RST_N deasserts.

Configuration
REQ-027 Macro MUX2_ARB_TIMEOUT_EN defined: if the owner holds for MAX_HOLD cycles while the other side requests, force GAP, pulse TMO for 1 cycle, and give the next grant to the waiting side.
REQ-028 Macro undefined: no hold counter; the owner keeps the mux until DONE or request drop; TMO is tied 0.

Structure
REQ-029 Shared package mux2_arb_pkg holds the state encoding constants (IDLE=2'b00, GRANT_A=2'b01, GRANT_B=2'b10, GAP=2'b11), the SEL_A/SEL_B constants, and the default SWITCH_GAP and MAX_HOLD values.
REQ-030 One sub-module, mux2_arb_timer, is a loadable down-counter used for both the GAP count and the hold count; the mux datapath stays outside this block.

Verification
REQ-031 Reset, then REQ_A=1 at cycle 2 -> GNT_A=1, SEL=0 at cycle 3; BUSY=1.
REQ-032 REQ_A=REQ_B=1 from reset -> A granted first; DONE -> 1 gap cycle -> GNT_B=1, SEL=1; repeat -> strict alternation.
REQ-033 SWITCH_GAP=3, owner A drops REQ_A -> exactly 3 cycles with both grants low, then B is granted.
REQ-034 RST_N pulled low mid-GRANT_B, between edges -> GNT_B=0 and SEL=0 before the next edge.
REQ-035 Timeout macro on, MAX_HOLD=4, A holds while B requests -> GNT_A falls after 4 cycles, TMO pulses, B is granted after the gap; macro off -> A holds indefinitely.
REQ-036 DONE asserted in IDLE or GAP -> no state change; the mutual-exclusion assertion on GNT_A/GNT_B never fires.
